// File: rtl/mm_stream_sequencer_if.sv
// Stream bundle of the matrix-multiply sequencer.
// master = sequencer side, slave = stream environment side.
interface mm_stream_sequencer_if;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TREADY;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TREADY;

    modport master (
        input  S_AXIS_TDATA,
        input  S_AXIS_TVALID,
        input  S_AXIS_TLAST,
        output S_AXIS_TREADY,
        output M_AXIS_TDATA,
        output M_AXIS_TVALID,
        output M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport slave (
        output S_AXIS_TDATA,
        output S_AXIS_TVALID,
        output S_AXIS_TLAST,
        input  S_AXIS_TREADY,
        input  M_AXIS_TDATA,
        input  M_AXIS_TVALID,
        input  M_AXIS_TLAST,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/mm_stream_sequencer.sv
// Sequences stream input into A/B RAMs, runs the multiplier,
// then streams RES RAM out through a one-word skid buffer.
module mm_stream_sequencer #(
    parameter int width          = 8,
    parameter int A_depth_bits   = 9,
    parameter int B_depth_bits   = 3,
    parameter int RES_depth_bits = 6
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    mm_stream_sequencer_if.master     axis,
    output logic                      A_write_en,
    output logic [A_depth_bits-1:0]   A_write_address,
    output logic [width-1:0]          A_write_data_in,
    output logic                      B_write_en,
    output logic [B_depth_bits-1:0]   B_write_address,
    output logic [width-1:0]          B_write_data_in,
    output logic                      RES_read_en,
    output logic [RES_depth_bits-1:0] RES_read_address,
    input  logic [width-1:0]          RES_read_data_out,
    output logic                      mm_start,
    input  logic                      mm_done,
    output logic                      busy,
    output logic                      frame_err
);

    typedef enum logic [2:0] {
        RECV_A, RECV_B, START, COMPUTE, SEND
    } state_t;

    state_t state, state_nxt;

    logic [A_depth_bits-1:0]   a_cnt;
    logic [B_depth_bits-1:0]   b_cnt;
    logic [RES_depth_bits:0]   rd_cnt;
    logic [RES_depth_bits-1:0] out_cnt;
    logic [width-1:0]          hold;
    logic [width-1:0]          in_word;
    logic [width-1:0]          out_word;
    logic hold_v, pend, armed, s_ready;
    logic hs, a_last, b_last, abort, b_miss;
    logic pop, keep, issue, last_pop;
    logic unused_tdata;

    assign in_word      = axis.S_AXIS_TDATA[width-1:0];
    assign unused_tdata = ^axis.S_AXIS_TDATA[31:width];

    assign s_ready = armed &
                     ((state == RECV_A) | (state == RECV_B));
    assign axis.S_AXIS_TREADY = s_ready;

    assign hs     = axis.S_AXIS_TVALID & s_ready;
    assign a_last = &a_cnt;
    assign b_last = &b_cnt;
    assign abort  = hs & axis.S_AXIS_TLAST &
                    ((state == RECV_A) |
                     ((state == RECV_B) & !b_last));
    assign b_miss = hs & (state == RECV_B) & b_last &
                    !axis.S_AXIS_TLAST;

    // At most one word is ever buffered or in flight: a new read
    // is issued only when nothing will be left waiting next cycle.
    assign pop      = axis.M_AXIS_TVALID & axis.M_AXIS_TREADY;
    assign keep     = (hold_v | pend) & !pop;
    assign last_pop = pop & (&out_cnt);
    assign issue    = (state == SEND) &
                      !rd_cnt[RES_depth_bits] & !keep;

    assign out_word = hold_v ? hold :
                      pend   ? RES_read_data_out : '0;

    assign axis.M_AXIS_TVALID = hold_v | pend;
    assign axis.M_AXIS_TDATA  = {{(32-width){1'b0}}, out_word};
    assign axis.M_AXIS_TLAST  = (hold_v | pend) & (&out_cnt);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= RECV_A;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RECV_A: begin
                if (abort)
                    state_nxt = RECV_A;
                else if (hs & a_last)
                    state_nxt = RECV_B;
            end
            RECV_B: begin
                if (abort)
                    state_nxt = RECV_A;
                else if (hs & b_last)
                    state_nxt = START;
            end
            START:   state_nxt = COMPUTE;
            COMPUTE: if (mm_done) state_nxt = SEND;
            SEND:    if (last_pop) state_nxt = RECV_A;
            default: state_nxt = RECV_A;
        endcase
    end

    always_comb begin
        A_write_en       = 1'b0;
        A_write_address  = a_cnt;
        A_write_data_in  = '0;
        B_write_en       = 1'b0;
        B_write_address  = b_cnt;
        B_write_data_in  = '0;
        mm_start         = 1'b0;
        RES_read_en      = issue;
        RES_read_address = rd_cnt[RES_depth_bits-1:0];
        busy = !((state == RECV_A) && (a_cnt == '0));
        unique case (state)
            RECV_A: begin
                A_write_en      = hs;
                A_write_data_in = hs ? in_word : '0;
            end
            RECV_B: begin
                B_write_en      = hs;
                B_write_data_in = hs ? in_word : '0;
            end
            START:   mm_start = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            armed     <= 1'b0;
            a_cnt     <= '0;
            b_cnt     <= '0;
            frame_err <= 1'b0;
        end else begin
            armed     <= 1'b1;
            frame_err <= abort | b_miss;
            if (abort) begin
                a_cnt <= '0;
                b_cnt <= '0;
            end else if (hs & (state == RECV_A)) begin
                a_cnt <= a_cnt + 1'b1;
            end else if (hs & (state == RECV_B)) begin
                b_cnt <= b_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_cnt  <= '0;
            out_cnt <= '0;
            hold    <= '0;
            hold_v  <= 1'b0;
            pend    <= 1'b0;
        end else begin
            pend   <= issue;
            hold_v <= keep;
            if (pend)
                hold <= RES_read_data_out;
            if (pop)
                out_cnt <= out_cnt + 1'b1;
            if (last_pop)
                rd_cnt <= '0;
            else if (issue)
                rd_cnt <= rd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mm_stream_sequencer.sv
// Directed bench for mm_stream_sequencer with a frame-level
// reference model checked on every falling clock edge.
module tb_mm_stream_sequencer;

    localparam int NA = 512;
    localparam int NB = 8;
    localparam int NR = 64;
    localparam int NW = NA + NB;

    logic       ACLK;
    logic       ARESETN;
    logic       A_write_en;
    logic [8:0] A_write_address;
    logic [7:0] A_write_data_in;
    logic       B_write_en;
    logic [2:0] B_write_address;
    logic [7:0] B_write_data_in;
    logic       RES_read_en;
    logic [5:0] RES_read_address;
    logic [7:0] RES_read_data_out;
    logic       mm_start, mm_done, busy, frame_err;
    logic       mult_done, extra_done;
    bit         stall;

    logic [7:0] a_mem [NA];
    logic [7:0] b_mem [NB];
    logic [7:0] res_mem [NR];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    mm_stream_sequencer_if axis ();

    mm_stream_sequencer dut (
        .ACLK              (ACLK),
        .ARESETN           (ARESETN),
        .axis              (axis),
        .A_write_en        (A_write_en),
        .A_write_address   (A_write_address),
        .A_write_data_in   (A_write_data_in),
        .B_write_en        (B_write_en),
        .B_write_address   (B_write_address),
        .B_write_data_in   (B_write_data_in),
        .RES_read_en       (RES_read_en),
        .RES_read_address  (RES_read_address),
        .RES_read_data_out (RES_read_data_out),
        .mm_start          (mm_start),
        .mm_done           (mm_done),
        .busy              (busy),
        .frame_err         (frame_err)
    );

    assign mm_done = mult_done | extra_done;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic logic [7:0] pat(input int p);
        return (p < NA) ? 8'(p % 256) : 8'(p - NA + 1);
    endfunction

    // Environment: RAMs and multiplier.
    always @(posedge ACLK) begin
        if (A_write_en) a_mem[A_write_address] <= A_write_data_in;
        if (B_write_en) b_mem[B_write_address] <= B_write_data_in;
        if (RES_read_en) RES_read_data_out <= res_mem[RES_read_address];
    end

    initial begin
        mult_done = 1'b0;
        forever begin
            @(negedge ACLK);
            if (mm_start) begin
                for (int r = 0; r < NR; r++) res_mem[r] = 8'(r + 100);
                repeat (5) @(posedge ACLK);
                #1 mult_done = 1'b1;
                @(posedge ACLK);
                #1 mult_done = 1'b0;
            end
        end
    end

    initial begin
        axis.M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            axis.M_AXIS_TREADY = stall ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // Reference model: phase 0 receive, 1 start, 2 compute, 3 send.
    int m_phase = 0;
    int m_pos   = 0;
    int m_scyc  = 0;
    int m_opos  = 0;
    bit m_armed = 0;
    bit m_err   = 0;

    initial forever begin
        @(posedge ACLK or negedge ARESETN);
        if (!ARESETN) begin
            m_phase = 0; m_pos = 0; m_scyc = 0;
            m_opos = 0; m_armed = 0; m_err = 0;
        end else begin
            m_err = 0;
            case (m_phase)
                0: if (m_armed && axis.S_AXIS_TVALID) begin
                    if (m_pos == NW - 1) begin
                        m_err = !axis.S_AXIS_TLAST;
                        m_phase = 1;
                        m_pos = 0;
                    end else if (axis.S_AXIS_TLAST) begin
                        m_err = 1;
                        m_pos = 0;
                    end else begin
                        m_pos++;
                    end
                end
                1: m_phase = 2;
                2: if (mm_done) begin
                    m_phase = 3; m_scyc = 0; m_opos = 0;
                end
                default: begin
                    if (m_scyc >= 1 && axis.M_AXIS_TREADY) begin
                        if (m_opos == NR - 1) m_phase = 0;
                        else m_opos++;
                    end
                    m_scyc++;
                end
            endcase
            m_armed = 1;
        end
    end

    bit m_ready, exp_hs, exp_a, exp_b, exp_v;

    initial forever begin
        @(negedge ACLK);
        m_ready = m_armed && m_phase == 0;
        exp_hs  = m_ready && axis.S_AXIS_TVALID;
        exp_a   = exp_hs && m_pos < NA;
        exp_b   = exp_hs && m_pos >= NA;
        exp_v   = m_phase == 3 && m_scyc >= 1;
        chk("s_tready", axis.S_AXIS_TREADY, m_ready);
        chk("a_we", A_write_en, exp_a);
        if (exp_a) begin
            chk("a_addr", A_write_address, m_pos);
            chk("a_data", A_write_data_in, pat(m_pos));
        end
        chk("b_we", B_write_en, exp_b);
        if (exp_b) begin
            chk("b_addr", B_write_address, m_pos - NA);
            chk("b_data", B_write_data_in, pat(m_pos));
        end
        chk("mm_start", mm_start, m_phase == 1);
        chk("busy", busy, !(m_phase == 0 && m_pos == 0));
        chk("frame_err", frame_err, m_err);
        chk("m_tvalid", axis.M_AXIS_TVALID, exp_v);
        if (exp_v) begin
            chk("m_tdata", axis.M_AXIS_TDATA, 100 + m_opos);
            chk("m_tlast", axis.M_AXIS_TLAST, m_opos == NR - 1);
        end
        if (m_phase != 3) chk("res_re_idle", RES_read_en, 0);
        if (!ARESETN) chk("m_tdata_rst", axis.M_AXIS_TDATA, 0);
    end

    // Observation counters for frame-level literal checks.
    int n_start = 0, n_err = 0, n_last = 0;
    int done_cyc = 0, first_v = -1, last_cyc = 0;
    int outq [$];

    initial forever begin
        @(negedge ACLK);
        if (mm_start) n_start++;
        if (frame_err) n_err++;
        if (mm_done) done_cyc = cyc;
        if (axis.M_AXIS_TVALID && first_v < 0) first_v = cyc;
        if (axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
            outq.push_back(int'(axis.M_AXIS_TDATA));
            if (axis.M_AXIS_TLAST) begin
                n_last++;
                last_cyc = cyc;
            end
        end
    end

    task automatic send_frame(input int nwords, input int tlast_at,
                              input bit gaps);
        int wt;
        for (int i = 0; i < nwords; i++) begin
            if (gaps) begin
                while ($urandom_range(1, 0) == 1) begin
                    axis.S_AXIS_TVALID = 1'b0;
                    @(posedge ACLK);
                    #1;
                end
            end
            axis.S_AXIS_TDATA  = {24'($urandom), pat(i)};
            axis.S_AXIS_TLAST  = (i == tlast_at);
            axis.S_AXIS_TVALID = 1'b1;
            wt = 0;
            do begin
                @(negedge ACLK);
                wt++;
            end while (!axis.S_AXIS_TREADY && wt < 3000);
            if (!axis.S_AXIS_TREADY) begin
                timeout("s_handshake");
                i = nwords;
            end
            @(posedge ACLK);
            #1;
        end
        axis.S_AXIS_TVALID = 1'b0;
        axis.S_AXIS_TLAST  = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int w = 0;
        while (n_last < target && w < 5000) begin
            @(posedge ACLK);
            w++;
        end
        #1;
        if (n_last < target) timeout("out_frame");
    endtask

    task automatic pulse_extra_done();
        extra_done = 1'b1;
        @(posedge ACLK);
        #1 extra_done = 1'b0;
    endtask

    task automatic check_out(input string tag);
        int bad = 0;
        chk({tag, "_count"}, outq.size(), NR);
        foreach (outq[i]) if (outq[i] != 100 + i) bad++;
        chk({tag, "_seq"}, bad, 0);
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < NA; i++) if (a_mem[i] !== pat(i)) bad++;
        for (int j = 0; j < NB; j++) if (b_mem[j] !== pat(NA + j)) bad++;
        chk({tag, "_mem"}, bad, 0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NA; i++) a_mem[i] = 8'hEE;
        for (int j = 0; j < NB; j++) b_mem[j] = 8'hEE;
    endtask

    int s0, e0, l0;

    task automatic frame_begin();
        s0 = n_start;
        e0 = n_err;
        l0 = n_last;
        outq.delete();
        first_v = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN = 1'b0;
        extra_done = 1'b0;
        stall = 1'b0;
        axis.S_AXIS_TDATA = '0;
        axis.S_AXIS_TVALID = 1'b0;
        axis.S_AXIS_TLAST = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_s_tready", axis.S_AXIS_TREADY, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_tvalid", axis.M_AXIS_TVALID, 0);
        @(negedge ACLK);
        #2 ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        chk("tready_after_rst", axis.S_AXIS_TREADY, 1);

        // Spurious Done while idle.
        pulse_extra_done();
        repeat (3) @(posedge ACLK);
        #1;
        chk("idle_done_busy", busy, 0);
        chk("idle_done_tvalid", axis.M_AXIS_TVALID, 0);

        // Nominal frame.
        clear_mem();
        frame_begin();
        send_frame(NW, NW - 1, 0);
        wait_out(l0 + 1);
        chk("nom_starts", n_start - s0, 1);
        chk("nom_errs", n_err - e0, 0);
        check_out("nom");
        chk("nom_first", outq[0], 100);
        chk("nom_last", outq[NR - 1], 163);
        chk("nom_latency", first_v - done_cyc, 2);
        chk("nom_burst", last_cyc - first_v, NR - 1);
        chk("nom_a300", a_mem[300], 44);
        chk("nom_a511", a_mem[511], 255);
        chk("nom_b0", b_mem[0], 1);
        chk("nom_b7", b_mem[7], 8);
        check_mem("nom");

        // Input gaps, output stalls, Done spuriously mid-receive.
        clear_mem();
        frame_begin();
        stall = 1'b1;
        fork
            send_frame(NW, NW - 1, 1);
            begin
                repeat (100) @(posedge ACLK);
                #1 pulse_extra_done();
            end
        join
        wait_out(l0 + 1);
        stall = 1'b0;
        chk("gap_starts", n_start - s0, 1);
        chk("gap_errs", n_err - e0, 0);
        check_out("gap");
        check_mem("gap");

        // Early TLAST on word 300, then a full frame.
        frame_begin();
        send_frame(301, 300, 0);
        repeat (5) @(posedge ACLK);
        #1;
        chk("early_errs", n_err - e0, 1);
        chk("early_starts", n_start - s0, 0);
        chk("early_busy", busy, 0);
        clear_mem();
        frame_begin();
        send_frame(NW, NW - 1, 0);
        wait_out(l0 + 1);
        chk("after_early_starts", n_start - s0, 1);
        check_out("after_early");
        check_mem("after_early");

        // Missing TLAST on the final word.
        frame_begin();
        send_frame(NW, -1, 0);
        wait_out(l0 + 1);
        chk("miss_errs", n_err - e0, 1);
        chk("miss_starts", n_start - s0, 1);
        check_out("miss");

        // Reset in the middle of SEND.
        frame_begin();
        send_frame(NW, NW - 1, 0);
        begin
            int w = 0;
            while (outq.size() < 10 && w < 2000) begin
                @(posedge ACLK);
                w++;
            end
            if (outq.size() < 10) timeout("mid_send");
        end
        #1 ARESETN = 1'b0;
        #1;
        chk("mr_m_tvalid", axis.M_AXIS_TVALID, 0);
        chk("mr_m_tdata", axis.M_AXIS_TDATA, 0);
        chk("mr_m_tlast", axis.M_AXIS_TLAST, 0);
        chk("mr_res_re", RES_read_en, 0);
        chk("mr_s_tready", axis.S_AXIS_TREADY, 0);
        chk("mr_busy", busy, 0);
        chk("mr_outq", outq.size(), 10);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        #2 ARESETN = 1'b1;
        @(posedge ACLK);
        #1;
        chk("mr_tready_up", axis.S_AXIS_TREADY, 1);
        pulse_extra_done();
        repeat (4) @(posedge ACLK);
        #1;
        chk("mr_stale_tvalid", axis.M_AXIS_TVALID, 0);
        chk("mr_stale_busy", busy, 0);
        clear_mem();
        frame_begin();
        send_frame(NW, NW - 1, 0);
        wait_out(l0 + 1);
        chk("mr_starts", n_start - s0, 1);
        check_out("mr_fresh");
        check_mem("mr_fresh");

        repeat (3) @(posedge ACLK);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
